// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: channel widths, default pass thresholds shared with
// the chroma-key compositor, calibration FSM states and saturating arithmetic helpers.
package pipeline_pkg;

  localparam int unsigned PixelSize  = 16;
  localparam int unsigned RedSize    = 5;
  localparam int unsigned GreenSize  = 6;
  localparam int unsigned BlueSize   = PixelSize - RedSize - GreenSize;

  // Thresholds the compositor uses when no calibration data is available.
  localparam logic [RedSize-1:0]   DefRedPass   = 5'b00100;
  localparam logic [GreenSize-1:0] DefGreenPass = 6'b101100;
  localparam logic [BlueSize-1:0]  DefBluePass  = 5'b01100;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSample,
    StFinish,
    StDone
  } cal_state_e;

  // a + b clamped to max_val; computed one bit wider so it never wraps.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] max_val);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[7:0];
  endfunction

  // a - b clamped to zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/pipeline_channel_extrema.sv
// Running maximum (IsMax=1) or minimum (IsMax=0) of one colour channel, with clear.
module pipeline_channel_extrema #(
  parameter int unsigned Width = 5,
  parameter bit          IsMax = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             update_i,
  input  logic [Width-1:0] value_i,
  output logic [Width-1:0] extreme_o
);

  localparam logic [Width-1:0] Init = IsMax ? {Width{1'b0}} : {Width{1'b1}};

  logic better;
  assign better = IsMax ? (value_i > extreme_o) : (value_i < extreme_o);

  // Track the extreme value seen since the last clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      extreme_o <= Init;
    end else if (clear_i) begin
      extreme_o <= Init;
    end else if (update_i && better) begin
      extreme_o <= value_i;
    end
  end

endmodule

// File: rtl/pipeline_chroma_key_calibrate.sv
// Chroma-key threshold calibration: samples one frame of foreground pixels inside a
// window, tracks per-channel extrema and presents margin-adjusted pass thresholds.
module pipeline_chroma_key_calibrate
  import pipeline_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = 16,
  parameter int unsigned RED_SIZE   = 5,
  parameter int unsigned GREEN_SIZE = 6,
  parameter int unsigned COORD_SIZE = 10,
  parameter int unsigned MARGIN     = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  frame_start,
  input  logic                                  pixel_valid,
  input  logic [PIXEL_SIZE-1:0]                 fg_pixel_in,
  input  logic [COORD_SIZE-1:0]                 pixel_x,
  input  logic [COORD_SIZE-1:0]                 pixel_y,
  input  logic [COORD_SIZE-1:0]                 win_x0,
  input  logic [COORD_SIZE-1:0]                 win_y0,
  input  logic [COORD_SIZE-1:0]                 win_x1,
  input  logic [COORD_SIZE-1:0]                 win_y1,
  output logic                                  busy,
  output logic                                  thr_valid,
  input  logic                                  thr_ready,
  output logic [RED_SIZE-1:0]                   red_pass,
  output logic [GREEN_SIZE-1:0]                 green_pass,
  output logic [PIXEL_SIZE-RED_SIZE-GREEN_SIZE-1:0] blue_pass,
  output logic                                  empty_window
);

  localparam int unsigned BLUE_SIZE = PIXEL_SIZE - RED_SIZE - GREEN_SIZE;
  localparam int unsigned CNT_SIZE  = 2 * COORD_SIZE;

  cal_state_e state_q;

  logic                  in_win, sample_en, clear;
  logic                  hit_q;
  logic [RED_SIZE-1:0]   red_q, red_max;
  logic [GREEN_SIZE-1:0] green_q, green_min;
  logic [BLUE_SIZE-1:0]  blue_q, blue_max;
  logic [CNT_SIZE-1:0]   count_q;

  // An inverted window naturally fails one of the two comparisons.
  assign in_win = (pixel_x >= win_x0) && (pixel_x <= win_x1) &&
                  (pixel_y >= win_y0) && (pixel_y <= win_y1);

  // Opening frame_start pixel counts; closing frame_start pixel does not.
  assign sample_en = ((state_q == StArmed) && frame_start) ||
                     ((state_q == StSample) && !frame_start);

  assign clear = (state_q == StIdle) && start;

  // Register stage on the pixel and window compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q   <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hit_q   <= sample_en && pixel_valid && in_win;
      red_q   <= fg_pixel_in[PIXEL_SIZE-1 -: RED_SIZE];
      green_q <= fg_pixel_in[BLUE_SIZE +: GREEN_SIZE];
      blue_q  <= fg_pixel_in[BLUE_SIZE-1:0];
    end
  end

  pipeline_channel_extrema #(.Width(RED_SIZE), .IsMax(1'b1)) u_red_max (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (clear),
    .update_i  (hit_q),
    .value_i   (red_q),
    .extreme_o (red_max)
  );

  pipeline_channel_extrema #(.Width(GREEN_SIZE), .IsMax(1'b0)) u_green_min (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (clear),
    .update_i  (hit_q),
    .value_i   (green_q),
    .extreme_o (green_min)
  );

  pipeline_channel_extrema #(.Width(BLUE_SIZE), .IsMax(1'b1)) u_blue_max (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (clear),
    .update_i  (hit_q),
    .value_i   (blue_q),
    .extreme_o (blue_max)
  );

  // Saturating count of in-window pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (hit_q && (count_q != {CNT_SIZE{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Calibration FSM with registered status and threshold outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      thr_valid    <= 1'b0;
      red_pass     <= RED_SIZE'(DefRedPass);
      green_pass   <= GREEN_SIZE'(DefGreenPass);
      blue_pass    <= BLUE_SIZE'(DefBluePass);
      empty_window <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StArmed;
            busy    <= 1'b1;
          end
        end
        StArmed: begin
          if (frame_start) state_q <= StSample;
        end
        StSample: begin
          if (frame_start) state_q <= StFinish;
        end
        StFinish: begin
          state_q   <= StDone;
          thr_valid <= 1'b1;
          if (count_q == '0) begin
            red_pass     <= RED_SIZE'(DefRedPass);
            green_pass   <= GREEN_SIZE'(DefGreenPass);
            blue_pass    <= BLUE_SIZE'(DefBluePass);
            empty_window <= 1'b1;
          end else begin
            red_pass     <= RED_SIZE'(sat_add(8'(red_max), 8'(MARGIN),
                                              8'({RED_SIZE{1'b1}})));
            green_pass   <= GREEN_SIZE'(sat_sub(8'(green_min), 8'(MARGIN)));
            blue_pass    <= BLUE_SIZE'(sat_add(8'(blue_max), 8'(MARGIN),
                                               8'({BLUE_SIZE{1'b1}})));
            empty_window <= 1'b0;
          end
        end
        StDone: begin
          if (thr_ready) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            thr_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_chroma_key_calibrate.sv
// Directed self-checking bench for pipeline_chroma_key_calibrate.
module tb_pipeline_chroma_key_calibrate;

  logic       clk = 1'b0;
  logic       reset, start, frame_start, pixel_valid, thr_ready;
  logic [15:0] fg_pixel_in;
  logic [9:0]  pixel_x, pixel_y, win_x0, win_y0, win_x1, win_y1;
  logic        busy, thr_valid, empty_window;
  logic [4:0]  red_pass, blue_pass;
  logic [5:0]  green_pass;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_chroma_key_calibrate dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .fg_pixel_in  (fg_pixel_in),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .win_x0       (win_x0),
    .win_y0       (win_y0),
    .win_x1       (win_x1),
    .win_y1       (win_y1),
    .busy         (busy),
    .thr_valid    (thr_valid),
    .thr_ready    (thr_ready),
    .red_pass     (red_pass),
    .green_pass   (green_pass),
    .blue_pass    (blue_pass),
    .empty_window (empty_window)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus starting at a negedge; returns at the next negedge.
  task automatic send_px(input int x, input int y, input int r, input int g, input int b,
                         input bit fs, input bit pv);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    fg_pixel_in = {5'(r), 6'(g), 5'(b)};
    pixel_valid = pv;
    frame_start = fs;
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic set_win(input int x0, input int y0, input int x1, input int y1);
    win_x0 = 10'(x0);
    win_y0 = 10'(y0);
    win_x1 = 10'(x1);
    win_y1 = 10'(y1);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Closing frame_start, then FINISH (no valid yet), then DONE with results.
  task automatic close_check(input string tag, input int r, input int g, input int b,
                             input bit empty);
    send_px(0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk({tag, "_finish_nvalid"}, 32'(thr_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(thr_valid), 32'd1);
    chk({tag, "_red"}, 32'(red_pass), 32'(r));
    chk({tag, "_green"}, 32'(green_pass), 32'(g));
    chk({tag, "_blue"}, 32'(blue_pass), 32'(b));
    chk({tag, "_empty"}, 32'(empty_window), 32'(empty));
  endtask

  task automatic accept(input string tag);
    thr_ready = 1'b1;
    @(negedge clk);
    thr_ready = 1'b0;
    chk({tag, "_acc_valid"}, 32'(thr_valid), 32'd0);
    chk({tag, "_acc_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; thr_ready = 1'b0;
    fg_pixel_in = '0; pixel_x = '0; pixel_y = '0;
    set_win(10, 10, 19, 19);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(thr_valid), 32'd0);
    chk("rst_empty", 32'(empty_window), 32'd0);
    chk("rst_red", 32'(red_pass), 32'd4);
    chk("rst_green", 32'(green_pass), 32'd44);
    chk("rst_blue", 32'(blue_pass), 32'd12);
    reset = 1'b0;
    @(negedge clk);

    // Uniform frame R=3 G=50 B=8 -> 5/48/10.
    do_start("uni");
    send_px(10, 10, 3, 50, 8, 1'b1, 1'b1);
    send_px(15, 12, 3, 50, 8, 1'b0, 1'b1);
    send_px(19, 19, 3, 50, 8, 1'b0, 1'b1);
    close_check("uni", 5, 48, 10, 1'b0);

    // Consumer stalls for 10 cycles while start pulses are ignored.
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    chk("stall_valid", 32'(thr_valid), 32'd1);
    chk("stall_red", 32'(red_pass), 32'd5);
    chk("stall_green", 32'(green_pass), 32'd48);
    // Handshake and start in the same cycle: start is dropped.
    start = 1'b1;
    accept("uni");
    start = 1'b0;
    @(negedge clk);
    chk("hs_start_ignored", 32'(busy), 32'd0);
    chk("idle_hold_red", 32'(red_pass), 32'd5);
    chk("idle_hold_blue", 32'(blue_pass), 32'd10);

    // Saturation: R=31 G=1 B=30 -> 31/0/31.
    do_start("sat");
    send_px(12, 12, 31, 1, 30, 1'b1, 1'b1);
    close_check("sat", 31, 0, 31, 1'b0);
    accept("sat");

    // Out-of-window pixels ignored; last in-window pixel right before close.
    do_start("oow");
    send_px(0, 0, 0, 0, 0, 1'b1, 1'b0);
    send_px(0, 12, 31, 0, 31, 1'b0, 1'b1);
    send_px(12, 25, 31, 0, 31, 1'b0, 1'b1);
    send_px(12, 12, 2, 40, 3, 1'b0, 1'b1);
    close_check("oow", 4, 38, 5, 1'b0);
    accept("oow");

    // Inverted window matches nothing -> defaults and empty_window.
    set_win(20, 10, 5, 19);
    do_start("inv");
    send_px(12, 12, 1, 60, 1, 1'b1, 1'b1);
    send_px(25, 12, 1, 60, 1, 1'b0, 1'b1);
    close_check("inv", 4, 44, 12, 1'b1);
    accept("inv");
    set_win(10, 10, 19, 19);

    // Pixel while ARMED ignored; pixel on closing frame_start excluded.
    do_start("cls");
    send_px(11, 11, 31, 0, 31, 1'b0, 1'b1);
    send_px(0, 0, 0, 0, 0, 1'b1, 1'b0);
    send_px(12, 12, 5, 40, 2, 1'b0, 1'b1);
    send_px(13, 13, 20, 10, 28, 1'b1, 1'b1);
    chk("cls_finish_nvalid", 32'(thr_valid), 32'd0);
    @(negedge clk);
    chk("cls_valid", 32'(thr_valid), 32'd1);
    chk("cls_red", 32'(red_pass), 32'd7);
    chk("cls_green", 32'(green_pass), 32'd38);
    chk("cls_blue", 32'(blue_pass), 32'd4);
    accept("cls");

    // Pixel on opening frame_start included.
    do_start("opn");
    send_px(11, 11, 20, 30, 1, 1'b1, 1'b1);
    send_px(12, 12, 5, 40, 2, 1'b0, 1'b1);
    close_check("opn", 22, 28, 4, 1'b0);
    accept("opn");

    // Asynchronous reset mid-SAMPLE discards partial results.
    do_start("rst");
    send_px(12, 12, 31, 0, 31, 1'b1, 1'b1);
    send_px(13, 13, 31, 0, 31, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(thr_valid), 32'd0);
    chk("arst_red", 32'(red_pass), 32'd4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start("fresh");
    send_px(12, 12, 1, 60, 1, 1'b1, 1'b1);
    close_check("fresh", 3, 58, 3, 1'b0);
    accept("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_chroma_key_calibrate.md
# pipeline_chroma_key_calibrate

Threshold generator for the chroma-key stage: on request, observes one full frame of foreground RGB565 pixels inside a programmable rectangle, tracks per-channel extrema and produces the three pass thresholds (red max, green min, blue max) consumed by the chroma-key compositor. Sits beside the compositor on the foreground pixel stream, in the pixel clock domain, and hands results to the control side through a valid/ready handshake.

## Interface
- PIXEL_SIZE, 16, pixel width (RGB565)
- RED_SIZE, 5, red channel width
- GREEN_SIZE, 6, green channel width (blue = PIXEL_SIZE - RED_SIZE - GREEN_SIZE)
- COORD_SIZE, 10, width of x/y coordinates and window bounds
- MARGIN, 2, tolerance added to red/blue max and subtracted from green min
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle calibration request
- frame_start  in  1  one-cycle pulse at start of each frame
- pixel_valid  in  1  fg_pixel_in/pixel_x/pixel_y valid this cycle
- fg_pixel_in  in  PIXEL_SIZE  foreground pixel
- pixel_x, pixel_y  in  COORD_SIZE each  pixel coordinates
- win_x0, win_y0, win_x1, win_y1  in  COORD_SIZE each  inclusive sample window; stable from start until thr_valid
- busy  out  1  high in any state other than IDLE
- thr_valid  out  1  thresholds available
- thr_ready  in  1  consumer accepts thresholds
- red_pass  out  RED_SIZE  resulting red threshold
- green_pass  out  GREEN_SIZE  resulting green threshold
- blue_pass  out  blue width  resulting blue threshold
- empty_window  out  1  no pixel fell in window; thresholds are defaults

## Operation
- States: IDLE, ARMED, SAMPLE, FINISH, DONE.
- IDLE: start -> ARMED; extrema reset to red_max=0, green_min=all-ones, blue_max=0, count=0.
- ARMED: wait for frame_start -> SAMPLE. Pixel with pixel_valid in the same cycle as that frame_start is counted.
- SAMPLE: each pixel_valid with win_x0<=pixel_x<=win_x1 and win_y0<=pixel_y<=win_y1 updates red_max, green_min, blue_max, increments count (COORD_SIZE*2 bits, saturating). Next frame_start -> FINISH; pixel_valid coinciding with it is NOT counted.
- FINISH (one cycle): red_pass = min(red_max+MARGIN, 31); green_pass = max(green_min-MARGIN, 0); blue_pass = min(blue_max+MARGIN, 31); arithmetic one bit wider than channel, saturated, never wraps. If count==0: outputs take package defaults (5'b00100, 6'b101100, 5'b01100), empty_window=1. -> DONE.
- DONE: thr_valid=1, outputs stable; thr_valid&&thr_ready -> IDLE.
- Inverted window (x0>x1 or y0>y1) matches nothing -> empty_window path.
- start outside IDLE ignored. start and thr handshake in same DONE cycle: handshake completes, start ignored.
- Reset at any point: immediately IDLE, partial results discarded.

## Timing
- Reset values: busy=0, thr_valid=0, empty_window=0, red_pass/green_pass/blue_pass = package defaults.
- start registered: ARMED from cycle after start.
- Extrema updated in the cycle after the qualifying pixel_valid (one register stage on pixel/coordinate compare).
- Closing frame_start at cycle N: FINISH at N+1 (pending last pixel update folded in), thr_valid high from N+2.
- red/green/blue_pass and empty_window change only on FINISH -> DONE transition; hold last result in IDLE.
- thr_valid falls the cycle after accepted handshake; busy falls same cycle.

## Structure
- Shared pipeline_pkg: channel widths, default pass constants, state enum (IDLE..DONE), saturating add/sub helpers. Default constants shared with the compositor so both agree.
- One natural sub-module: pipeline_channel_extrema (per-channel running min or max with clear, parameterised width and direction), instantiated three times.

## Test plan
- Uniform frame: window 10..19 x 10..19, all pixels R=3,G=50,B=8 -> red_pass=5, green_pass=48, blue_pass=10, empty_window=0, thr_valid 2 cycles after second frame_start.
- Saturation: one in-window pixel R=31,G=1,B=30 -> red_pass=31, green_pass=0, blue_pass=31.
- Out-of-window only: pixels with R=31 at x=0 outside window, in-window R=2 -> red_pass=4; inverted window (x0=20,x1=5) -> defaults 4/44/12, empty_window=1.
- Frame_start coincidence: in-window pixel R=20 on closing frame_start excluded (red_pass from others); same pixel on opening frame_start included.
- Handshake: hold thr_ready=0 for 10 cycles -> thr_valid and outputs stable, start ignored; thr_ready=1 -> IDLE next cycle, busy=0.
- Reset mid-SAMPLE: assert reset -> busy=0, thr_valid=0 asynchronously; new start yields fresh result unaffected by earlier pixels.
